cp0_unit: RTL and testbench
===========================

Name: cp0_unit

Overview:
- Coprocessor-0 responder for the single-cycle MIPS core.
- Executes the mfc0, mtc0 and eret operations flagged by the main decoder.
- Holds the Status, Cause, EPC, Count and Compare registers.
- Synchronises external interrupt pins and runs the Count/Compare timer.
- Signals the fetch stage to redirect to the exception vector (interrupt taken) or to EPC (eret).

Parameters:
- EXC_VECTOR, 32'h0000_4180, PC loaded when an interrupt is taken.
- SYNC_STAGES, 2, flip-flop depth of each hardware-interrupt synchroniser (legal 2..3).

Ports:
- i_clk  input  1  rising-edge clock
- i_rst_n  input  1  synchronous active-low reset
- i_valid  input  1  instruction in execute is valid (not a bubble)
- i_pc  input  32  PC of the instruction in execute
- i_mtc0  input  1  decoder mtc0 flag
- i_mfc0  input  1  decoder mfc0 flag
- i_eret  input  1  decoder eret flag
- i_sel  input  5  CP0 register number (rd field)
- i_wdata  input  32  GPR rt value for mtc0
- i_hw_int  input  6  asynchronous interrupt pins, active-high level
- o_rdata  output  32  mfc0 read data (combinational)
- o_exc_take  output  1  interrupt taken this cycle; flush current instruction
- o_exc_pc  output  32  EXC_VECTOR when o_exc_take, else EPC
- o_eret_take  output  1  eret retiring this cycle; next PC = o_exc_pc
- o_exl  output  1  Status.EXL

Behaviour:
- Reset (i_rst_n=0 at clock edge):
  - Status, Cause, EPC, Count, Compare = 0.
  - Synchronisers cleared.
  - Outputs: o_rdata=0, o_exc_take=0, o_eret_take=0, o_exl=0, o_exc_pc=0.
  - Reset overrides every other event in the same cycle.
- Register map (any other i_sel reads 0; writes to it ignored):
  - 9 Count: RW. Increments by 1 every cycle, wrapping 0xFFFFFFFF->0. An mtc0 write loads i_wdata instead of incrementing.
  - 11 Compare: RW. Any mtc0 write clears Cause.TI.
  - 12 Status: writable bits IM[15:8], EXL[1], IE[0]; all other bits read 0.
  - 13 Cause: TI[30] RO; IP[15:10] RO; IP[9:8] RW (software interrupts); ExcCode[6:2] RO; all other bits read 0.
  - 14 EPC: RW.
- Interrupt input path:
  - Each i_hw_int bit passes through a SYNC_STAGES synchroniser.
  - The synchroniser output is registered into Cause.IP[15:10] every cycle, with IP[15] = sync[5] | TI.
  - Pin rise to Cause.IP visible = SYNC_STAGES+1 cycles.
- Timer: at any edge where Count == Compare and Compare != 0, TI <= 1. TI stays set until Compare is written.
- Interrupt take:
  - pending = |(Cause.IP[15:8] & Status.IM[15:8]).
  - o_exc_take = i_valid & Status.IE & ~Status.EXL & pending (combinational, same cycle).
  - On the edge: EPC <= i_pc, EXL <= 1, ExcCode <= 0.
  - The current instruction is squashed; any i_mtc0 in that cycle is suppressed.
- ERET:
  - o_eret_take = i_valid & i_eret & ~o_exc_take.
  - On the edge: EXL <= 0.
  - o_exc_pc = EPC during that cycle.
  - eret with EXL=0 still clears EXL (no-op) and still redirects.
- mtc0:
  - Writes on the edge when i_valid & i_mtc0 & ~o_exc_take.
  - An interrupt-take update of EXL/EPC/ExcCode in the same edge wins over the write (the write is suppressed anyway).
  - A Count write takes priority over its increment.
- mfc0:
  - o_rdata = current register value by i_sel whenever i_mfc0 & i_valid, else 0.
  - A read in the same cycle as an mtc0 to the same register returns the old value.
- Flag conflicts: simultaneous i_mtc0/i_mfc0/i_eret are decoder errors. Priority is eret > mtc0; mfc0 is read-only and unaffected.
- i_valid=0: no architectural update except Count increment, timer TI, and Cause.IP sampling.

Test Plan:
- Reset then mfc0 sel 12/13/14 -> o_rdata=0. mfc0 sel 9 after 10 cycles -> o_rdata=10 (±1 per mtc0 timing). mfc0 sel 5 -> 0.
- mtc0 Status=0x0000_FF01. Raise i_hw_int[2] with i_valid=1, i_pc=0x0000_3010 -> o_exc_take=1 exactly SYNC_STAGES+1 cycles after the pin rises, o_exc_pc=0x0000_4180. Next cycle: EPC=0x0000_3010, o_exl=1, Cause.IP[12]=1.
- With EXL=1 and the pin still high -> o_exc_take stays 0. eret -> o_eret_take=1, o_exc_pc=0x0000_3010. Next cycle o_exl=0 and the interrupt is retaken.
- mtc0 Compare=20, Count=15, Status=0x0000_8001 -> TI=1 and Cause bit 30 set at the edge where Count=20. o_exc_take asserts the following cycle. mtc0 Compare=100 -> TI=0.
- mtc0 Cause IP[8]=1 with IM[8]=1, IE=1 -> software interrupt taken the next valid cycle. mtc0 Cause=0xFFFF_FFFF -> only IP[9:8] change.
- Interrupt pending in the same cycle as mtc0 EPC=0x1234 -> write suppressed, EPC=i_pc. Assert i_rst_n=0 mid-interrupt -> all registers 0 next cycle, o_exc_take=0.

Source files
------------

// File: rtl/cp0_unit.sv
`default_nettype none
// ============================================================================
// Module   : cp0_unit
// Purpose  : Coprocessor-0 for the single-cycle MIPS core: Status/Cause/EPC,
//            Count/Compare timer, interrupt synchronisers, mfc0/mtc0/eret.
// Revision : 1.0 - initial release
// ============================================================================
module cp0_unit #(
    parameter logic [31:0] EXC_VECTOR  = 32'h0000_4180,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    input  logic [31:0] i_pc,
    input  logic        i_mtc0,
    input  logic        i_mfc0,
    input  logic        i_eret,
    input  logic [4:0]  i_sel,
    input  logic [31:0] i_wdata,
    input  logic [5:0]  i_hw_int,
    output logic [31:0] o_rdata,
    output logic        o_exc_take,
    output logic [31:0] o_exc_pc,
    output logic        o_eret_take,
    output logic        o_exl
);

    localparam logic [4:0] C_SEL_COUNT   = 5'd9;
    localparam logic [4:0] C_SEL_COMPARE = 5'd11;
    localparam logic [4:0] C_SEL_STATUS  = 5'd12;
    localparam logic [4:0] C_SEL_CAUSE   = 5'd13;
    localparam logic [4:0] C_SEL_EPC     = 5'd14;
    localparam int         C_SYNC_W      = SYNC_STAGES * 6;

    // Synchroniser chain: stage 0 in the low 6 bits, oldest stage on top.
    logic [C_SYNC_W-1:0] r_sync;
    logic [5:0]          w_sync_out;

    logic [7:0]  r_status_im;
    logic        r_status_exl;
    logic        r_status_ie;
    logic        r_cause_ti;
    logic [5:0]  r_cause_ip_hw;
    logic [1:0]  r_cause_ip_sw;
    logic [4:0]  r_cause_exccode;
    logic [31:0] r_epc;
    logic [31:0] r_count;
    logic [31:0] r_compare;

    logic        w_pending;
    logic        w_take;
    logic        w_eret_take;
    logic        w_wr;
    logic        w_ti_next;
    logic [31:0] w_status;
    logic [31:0] w_cause;

    assign w_sync_out = r_sync[C_SYNC_W-1 -: 6];

    assign w_pending   = |({r_cause_ip_hw, r_cause_ip_sw} & r_status_im);
    assign w_take      = i_valid & r_status_ie & ~r_status_exl & w_pending;
    assign w_eret_take = i_valid & i_eret & ~w_take;
    // eret outranks mtc0 when the decoder raises both.
    assign w_wr        = i_valid & i_mtc0 & ~w_take & ~i_eret;

    always_comb begin
        w_ti_next = r_cause_ti;
        if ((r_count == r_compare) && (r_compare != 32'd0)) begin
            w_ti_next = 1'b1;
        end
        if (w_wr && (i_sel == C_SEL_COMPARE)) begin
            w_ti_next = 1'b0;
        end
    end

    assign w_status = {16'd0, r_status_im, 6'd0, r_status_exl, r_status_ie};
    assign w_cause  = {1'b0, r_cause_ti, 14'd0, r_cause_ip_hw, r_cause_ip_sw,
                       1'b0, r_cause_exccode, 2'b00};

    always_comb begin
        o_rdata = 32'd0;
        if (i_mfc0 && i_valid) begin
            case (i_sel)
                C_SEL_COUNT:   o_rdata = r_count;
                C_SEL_COMPARE: o_rdata = r_compare;
                C_SEL_STATUS:  o_rdata = w_status;
                C_SEL_CAUSE:   o_rdata = w_cause;
                C_SEL_EPC:     o_rdata = r_epc;
                default:       o_rdata = 32'd0;
            endcase
        end
    end

    assign o_exc_take  = w_take;
    assign o_eret_take = w_eret_take;
    assign o_exc_pc    = w_take ? EXC_VECTOR : r_epc;
    assign o_exl       = r_status_exl;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[C_SYNC_W-7:0], i_hw_int};
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_status_im     <= 8'd0;
            r_status_exl    <= 1'b0;
            r_status_ie     <= 1'b0;
            r_cause_ti      <= 1'b0;
            r_cause_ip_hw   <= 6'd0;
            r_cause_ip_sw   <= 2'd0;
            r_cause_exccode <= 5'd0;
            r_epc           <= 32'd0;
            r_count         <= 32'd0;
            r_compare       <= 32'd0;
        end else begin
            r_cause_ti    <= w_ti_next;
            // Timer interrupt shares line 5 with the last hardware pin.
            r_cause_ip_hw <= {w_sync_out[5] | w_ti_next, w_sync_out[4:0]};
            r_count       <= (w_wr && (i_sel == C_SEL_COUNT)) ? i_wdata
                                                              : r_count + 32'd1;
            if (w_take) begin
                r_epc           <= i_pc;
                r_status_exl    <= 1'b1;
                r_cause_exccode <= 5'd0;
            end else if (w_eret_take) begin
                r_status_exl <= 1'b0;
            end else if (w_wr) begin
                case (i_sel)
                    C_SEL_COMPARE: r_compare <= i_wdata;
                    C_SEL_STATUS: begin
                        r_status_im  <= i_wdata[15:8];
                        r_status_exl <= i_wdata[1];
                        r_status_ie  <= i_wdata[0];
                    end
                    C_SEL_CAUSE:   r_cause_ip_sw <= i_wdata[9:8];
                    C_SEL_EPC:     r_epc <= i_wdata;
                    default:       ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cp0_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_cp0_unit
// Purpose  : Scoreboard bench for cp0_unit: directed scenarios plus random ops
//            against a register-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cp0_unit;

    localparam int          C_STAGES = 2;
    localparam logic [31:0] C_VEC    = 32'h0000_4180;

    logic        clk = 1'b0;
    logic        rst_n, valid, mtc0, mfc0, eret;
    logic [31:0] pc, wdata;
    logic [4:0]  sel;
    logic [5:0]  hw;
    logic [31:0] rdata, exc_pc;
    logic        exc_take, eret_take, exl;

    always #5 clk = ~clk;

    cp0_unit #(.EXC_VECTOR(C_VEC), .SYNC_STAGES(C_STAGES)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_pc(pc),
        .i_mtc0(mtc0), .i_mfc0(mfc0), .i_eret(eret), .i_sel(sel),
        .i_wdata(wdata), .i_hw_int(hw), .o_rdata(rdata),
        .o_exc_take(exc_take), .o_exc_pc(exc_pc),
        .o_eret_take(eret_take), .o_exl(exl)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        take;
        logic [31:0] pc_out;
        logic        eret;
        logic        exl;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: architectural register contents.
    logic [7:0]  m_im;
    logic        m_exl, m_ie, m_ti;
    logic [1:0]  m_sw;
    logic [5:0]  m_hw;
    logic [31:0] m_epc, m_count, m_cmp;
    logic [5:0]  pin_q[$];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] m_read(logic [4:0] s);
        case (s)
            5'd9:    return m_count;
            5'd11:   return m_cmp;
            5'd12:   return {16'd0, m_im, 6'd0, m_exl, m_ie};
            5'd13:   return {1'b0, m_ti, 14'd0, m_hw, m_sw, 8'd0};
            5'd14:   return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_reset();
        m_im = '0; m_exl = 0; m_ie = 0; m_ti = 0; m_sw = '0; m_hw = '0;
        m_epc = '0; m_count = '0; m_cmp = '0;
        pin_q = {};
        for (int i = 0; i < C_STAGES; i++) pin_q.push_back(6'd0);
    endtask

    task automatic step(input logic r, input logic v, input logic [31:0] p,
                        input logic wr_f, input logic rd_f, input logic er_f,
                        input logic [4:0] s, input logic [31:0] d,
                        input logic [5:0] h);
        exp_t        e;
        logic        tk, et, wr, ti_n;
        logic [5:0]  oldest;
        @(posedge clk);
        #1;
        rst_n = r; valid = v; pc = p; mtc0 = wr_f; mfc0 = rd_f; eret = er_f;
        sel = s; wdata = d; hw = h;
        tk = v & m_ie & ~m_exl & (|({m_hw, m_sw} & m_im));
        et = v & er_f & ~tk;
        e.take = tk; e.eret = et; e.exl = m_exl;
        e.pc_out = tk ? C_VEC : m_epc;
        e.rdata  = (rd_f && v) ? m_read(s) : 32'd0;
        sb_q.push_back(e);
        if (!r) begin
            m_reset();
        end else begin
            wr   = v & wr_f & ~tk & ~er_f;
            ti_n = m_ti;
            if (m_count == m_cmp && m_cmp != 0) ti_n = 1'b1;
            if (wr && s == 5'd11) ti_n = 1'b0;
            oldest = pin_q.pop_front();
            pin_q.push_back(h);
            m_ti = ti_n;
            m_hw = {oldest[5] | ti_n, oldest[4:0]};
            m_count = (wr && s == 5'd9) ? d : m_count + 1;
            if (tk) begin
                m_epc = p; m_exl = 1'b1;
            end else if (et) begin
                m_exl = 1'b0;
            end else if (wr) begin
                case (s)
                    5'd11: m_cmp = d;
                    5'd12: begin m_im = d[15:8]; m_exl = d[1]; m_ie = d[0]; end
                    5'd13: m_sw = d[9:8];
                    5'd14: m_epc = d;
                    default: ;
                endcase
            end
        end
    endtask

    task automatic nop(input logic [31:0] p, input logic [5:0] h);
        step(1, 1, p, 0, 0, 0, 5'd0, 32'd0, h);
    endtask
    task automatic wr0(input logic [4:0] s, input logic [31:0] d, input logic [31:0] p);
        step(1, 1, p, 1, 0, 0, s, d, 6'd0);
    endtask
    task automatic rd0(input logic [4:0] s, input logic [5:0] h);
        step(1, 1, 32'h100, 0, 1, 0, s, 32'd0, h);
    endtask
    task automatic rst_cycle();
        step(0, 0, 32'd0, 0, 0, 0, 5'd0, 32'd0, 6'd0);
    endtask

    // Monitor: every cycle the DUT presents one response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("rdata", rdata, e.rdata);
                chk("exc_take", {31'd0, exc_take}, {31'd0, e.take});
                chk("exc_pc", exc_pc, e.pc_out);
                chk("eret_take", {31'd0, eret_take}, {31'd0, e.eret});
                chk("exl", {31'd0, exl}, {31'd0, e.exl});
            end
        end
    end

    initial begin
        logic [31:0] cval;
        logic [4:0]  sel_tab [8];
        logic [5:0]  hcur;
        int          op;
        logic [4:0]  s;
        logic [31:0] d;
        logic        fm, fr, fe;
        sel_tab = '{5'd5, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd31};
        rst_n = 0; valid = 0; pc = 0; mtc0 = 0; mfc0 = 0; eret = 0;
        sel = 0; wdata = 0; hw = 0;
        m_reset();
        repeat (2) @(posedge clk);

        // Reset state and free-running Count.
        rd0(5'd12, 0); #2 chk("status_rst", rdata, 32'd0);
        rd0(5'd13, 0); #2 chk("cause_rst", rdata, 32'd0);
        rd0(5'd14, 0); #2 chk("epc_rst", rdata, 32'd0);
        rst_cycle();
        repeat (10) nop(32'h100, 0);
        rd0(5'd9, 0);  #2 chk("count_10", rdata, 32'd10);
        rd0(5'd5, 0);  #2 chk("sel5_zero", rdata, 32'd0);

        // Hardware interrupt through the synchroniser.
        wr0(5'd12, 32'h0000_FF01, 32'h100);
        for (int k = 0; k < C_STAGES + 1; k++) begin
            nop(32'h3010, 6'h04); #2 chk("hw_early", {31'd0, exc_take}, 32'd0);
        end
        nop(32'h3010, 6'h04); #2 chk("hw_take", {31'd0, exc_take}, 32'd1);
        chk("hw_vec", exc_pc, C_VEC);
        rd0(5'd14, 6'h04); #2 chk("epc_saved", rdata, 32'h3010);
        chk("exl_set", {31'd0, exl}, 32'd1);
        chk("exl_blocks", {31'd0, exc_take}, 32'd0);
        rd0(5'd13, 6'h04); #2 chk("cause_ip12", rdata, 32'h0000_1000);
        step(1, 1, 32'h200, 0, 0, 1, 5'd0, 32'd0, 6'h04);
        #2 chk("eret_take", {31'd0, eret_take}, 32'd1);
        chk("eret_pc", exc_pc, 32'h3010);
        nop(32'h3020, 6'h04); #2 chk("retake", {31'd0, exc_take}, 32'd1);

        // Count/Compare timer.
        rst_cycle();
        wr0(5'd12, 32'h0000_8001, 32'h100);
        wr0(5'd11, 32'd20, 32'h100);
        wr0(5'd9, 32'd15, 32'h100);
        for (int k = 0; k < 6; k++) begin
            nop(32'h400, 0); #2 chk("timer_early", {31'd0, exc_take}, 32'd0);
        end
        nop(32'h400, 0); #2 chk("timer_take", {31'd0, exc_take}, 32'd1);
        rd0(5'd13, 0); #2 cval = rdata; chk("ti_set", {31'd0, cval[30]}, 32'd1);
        wr0(5'd11, 32'd100, 32'h100);
        rd0(5'd13, 0); #2 chk("ti_clr", rdata, 32'd0);

        // Software interrupt and Cause write mask.
        rst_cycle();
        wr0(5'd12, 32'h0000_0101, 32'h100);
        wr0(5'd13, 32'h0000_0100, 32'h100);
        nop(32'h500, 0); #2 chk("sw_take", {31'd0, exc_take}, 32'd1);
        wr0(5'd13, 32'hFFFF_FFFF, 32'h100);
        rd0(5'd13, 0); #2 chk("cause_mask", rdata, 32'h0000_0300);

        // mtc0 suppressed by a simultaneous take, then reset mid-interrupt.
        rst_cycle();
        wr0(5'd12, 32'h0000_0101, 32'h100);
        wr0(5'd13, 32'h0000_0100, 32'h100);
        wr0(5'd14, 32'h0000_1234, 32'h5000);
        #2 chk("take_vs_mtc0", {31'd0, exc_take}, 32'd1);
        rd0(5'd14, 0); #2 chk("epc_not_written", rdata, 32'h5000);
        step(1, 1, 32'h600, 0, 0, 1, 5'd0, 32'd0, 6'd0);
        rst_cycle();
        rd0(5'd13, 0); #2 chk("rst_take", {31'd0, exc_take}, 32'd0);
        chk("rst_cause", rdata, 32'd0);

        // Randomised traffic.
        hcur = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) hcur = 6'($urandom);
            s  = sel_tab[$urandom_range(0, 7)];
            d  = $urandom;
            if (s == 5'd11 && $urandom_range(0, 1) == 1) d = m_count + 32'($urandom_range(1, 8));
            if (s == 5'd12 && $urandom_range(0, 1) == 1) d = (d & 32'h0000_FF00) | 32'h1;
            op = $urandom_range(0, 9);
            fm = (op >= 3 && op <= 5); fr = (op == 6 || op == 7); fe = (op == 8);
            if (op == 9) begin
                fm = 1'($urandom); fr = 1'($urandom); fe = 1'($urandom);
            end
            step(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1,
                 ($urandom_range(0, 4) != 0), $urandom & 32'hFFFF_FFFC,
                 fm, fr, fe, s, d, hcur);
        end

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
